// File: rtl/popcount_arbiter.sv
// popcount_arbiter: shares one bit_population_counter between REQ_NUM
// requesters. Words are granted one per cycle, forwarded to the counter,
// and each count is routed back to the requester that issued it.
// A tag FIFO remembers the owner of every word that is still in the counter.
// Optional feature macro: POPCOUNT_ARB_FIXED_PRIO_EN (fixed priority, lowest
// index wins, no rotating pointer). Default build is round-robin.
module popcount_arbiter #(
    parameter int WIDTH           = 8,
    parameter int REQ_NUM         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic [REQ_NUM-1:0][WIDTH-1:0]     req_data_i,
    input  logic [REQ_NUM-1:0]                req_val_i,
    output logic [REQ_NUM-1:0]                req_ready_o,
    output logic [WIDTH-1:0]                  cnt_data_o,
    output logic                              cnt_data_val_o,
    input  logic [$clog2(WIDTH):0]            cnt_data_i,
    input  logic                              cnt_data_val_i,
    output logic [$clog2(WIDTH):0]            rsp_data_o,
    output logic [REQ_NUM-1:0]                rsp_val_o,
    output logic                              err_o
);

    localparam int TAG_W  = $clog2(REQ_NUM);
    localparam int CRD_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int ADDR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CRD_W-1:0]  CRD_MAX   = CRD_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_OUTSTANDING - 1);

    // Credit count: words in the counter whose result has not come back.
    // It also equals the tag FIFO occupancy, so it doubles as the FIFO level.
    logic [CRD_W-1:0]  outst;
    logic              issue_en;
    logic              grant_found;
    logic [TAG_W-1:0]  grant_idx;
    logic              transfer;
    logic              pop;

    logic [TAG_W-1:0]  tag_mem [MAX_OUTSTANDING];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [TAG_W-1:0]  pop_tag;

    // Issue is judged on the registered credit count only, so a return in
    // the same cycle cannot open the gate early.
    assign issue_en = !srst_i && (outst < CRD_MAX);
    assign transfer = grant_found;
    assign pop      = cnt_data_val_i && (outst != '0);
    assign pop_tag  = tag_mem[rd_ptr];

`ifdef POPCOUNT_ARB_FIXED_PRIO_EN

    // Fixed priority: the lowest-index valid requester wins the grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready_o = '0;
        if (issue_en) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (!grant_found && req_val_i[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = TAG_W'(i);
                end
            end
            if (grant_found) begin
                req_ready_o[grant_idx] = 1'b1;
            end
        end
    end

`else

    localparam logic [TAG_W:0]   REQ_NUM_EXT = (TAG_W + 1)'(REQ_NUM);
    localparam logic [TAG_W-1:0] TAG_LAST    = TAG_W'(REQ_NUM - 1);

    logic [TAG_W-1:0] ptr;
    logic [TAG_W:0]   cand;

    // Round-robin: scan upward from ptr with wrap-around, first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready_o = '0;
        cand        = '0;
        if (issue_en) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                cand = {1'b0, ptr} + (TAG_W + 1)'(i);
                if (cand >= REQ_NUM_EXT) begin
                    cand = cand - REQ_NUM_EXT;
                end
                if (!grant_found && req_val_i[cand[TAG_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand[TAG_W-1:0];
                end
            end
            if (grant_found) begin
                req_ready_o[grant_idx] = 1'b1;
            end
        end
    end

    // Priority pointer moves just past the requester that was served.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_idx == TAG_LAST) ? '0 : grant_idx + 1'b1;
        end
    end

`endif

    // Credit counter: +1 per issue, -1 per matched return, both cancel.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            outst <= '0;
        end else begin
            case ({transfer, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (transfer) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    // FIFO pointers; reset empties the FIFO and discards in-flight owners.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (transfer) begin
                wr_ptr <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == ADDR_LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Counter side: register the granted word, pulse valid for one cycle.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_data_o     <= '0;
            cnt_data_val_o <= 1'b0;
        end else begin
            cnt_data_val_o <= transfer;
            if (transfer) begin
                cnt_data_o <= req_data_i[grant_idx];
            end
        end
    end

    // Response side: route each count to its owner; an orphan result is
    // dropped and latches the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rsp_data_o <= '0;
            rsp_val_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            rsp_val_o <= '0;
            if (cnt_data_val_i) begin
                if (pop) begin
                    rsp_data_o <= cnt_data_i;
                    rsp_val_o  <= REQ_NUM'(1) << pop_tag;
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_arbiter.sv
// tb_popcount_arbiter: directed bench for popcount_arbiter with a behavioural
// popcount counter of selectable latency. Expected responses go into a
// scoreboard queue; a monitor pops and compares whenever rsp_val_o is high.
// Honours POPCOUNT_ARB_FIXED_PRIO_EN for the priority scenario.
module tb_popcount_arbiter;

    localparam int WIDTH   = 8;
    localparam int REQ_NUM = 4;
    localparam int MAX_OUT = 4;
    localparam int CW      = $clog2(WIDTH) + 1;

    typedef struct packed {
        logic [REQ_NUM-1:0] owner;
        logic [CW-1:0]      count;
    } exp_t;

    logic                          clk;
    logic                          srst;
    logic [REQ_NUM-1:0][WIDTH-1:0] req_data;
    logic [REQ_NUM-1:0]            req_val;
    logic [REQ_NUM-1:0]            req_ready;
    logic [WIDTH-1:0]              cnt_data_o;
    logic                          cnt_data_val_o;
    logic [CW-1:0]                 cnt_data_i;
    logic                          cnt_data_val_i;
    logic [CW-1:0]                 rsp_data;
    logic [REQ_NUM-1:0]            rsp_val;
    logic                          err;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    int            lat = 1;
    logic          inject_val = 1'b0;
    logic [CW-1:0] inject_data = '0;
    logic [15:0]   pv;
    logic [CW-1:0] pd [16];
    logic          last_cnt_val = 1'b0;

    popcount_arbiter #(
        .WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk), .srst_i(srst),
        .req_data_i(req_data), .req_val_i(req_val), .req_ready_o(req_ready),
        .cnt_data_o(cnt_data_o), .cnt_data_val_o(cnt_data_val_o),
        .cnt_data_i(cnt_data_i), .cnt_data_val_i(cnt_data_val_i),
        .rsp_data_o(rsp_data), .rsp_val_o(rsp_val), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural in-order popcount counter sharing the arbiter's reset.
    always @(posedge clk) begin
        if (srst) begin
            pv <= '0;
        end else begin
            pv <= {pv[14:0], cnt_data_val_o};
            for (int i = 15; i > 0; i--) pd[i] <= pd[i-1];
            pd[0] <= CW'($countones(cnt_data_o));
        end
    end

    assign cnt_data_val_i = pv[lat-1] | inject_val;
    assign cnt_data_i     = inject_val ? inject_data : pd[lat-1];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [REQ_NUM-1:0] vals,
                                 input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                 input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        req_val     = vals;
        req_data[0] = d0;
        req_data[1] = d1;
        req_data[2] = d2;
        req_data[3] = d3;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) nextCycle();
    endtask

    task automatic doReset(input int new_lat);
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        srst = 1'b1;
        sb.delete();
        lat = new_lat;
        nextCycle();
        srst = 1'b0;
    endtask

    // Monitor: every response must match the oldest expected entry and
    // arrive one cycle after the counter result.
    always @(negedge clk) begin
        if (rsp_val != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_val), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_owner", 32'(rsp_val), 32'(e.owner));
                checkOutput("rsp_data", 32'(rsp_data), 32'(e.count));
                checkOutput("rsp_latency", 32'(last_cnt_val), 32'h1);
            end
        end
        last_cnt_val = cnt_data_val_i;
    end

    initial begin
        logic [CW-1:0]      rr_cnt [4];
        logic [REQ_NUM-1:0] exp_gnt;
        int                 stall;
        logic               found;

        rr_cnt[0] = 4'd8; rr_cnt[1] = 4'd0; rr_cnt[2] = 4'd4; rr_cnt[3] = 4'd1;

        // Reset values, with every requester valid during reset.
        srst = 1'b1;
        applyStimulus(4'hF, 8'hFF, 8'h00, 8'h0F, 8'h01);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_cnt_data", 32'(cnt_data_o), 32'h0);
        checkOutput("reset_cnt_val", 32'(cnt_data_val_o), 32'h0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'h0);
        checkOutput("reset_rsp_val", 32'(rsp_val), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        srst = 1'b0;

        // Single request from requester 2: 8'h0E has three ones.
        nextCycle();
        applyStimulus(4'b0100, 8'h00, 8'h00, 8'h0E, 8'h00);
        @(negedge clk);
        checkOutput("single_grant", 32'(req_ready), 32'h4);
        sb.push_back('{owner: 4'b0100, count: 4'd3});
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("single_cnt_data", 32'(cnt_data_o), 32'h0E);
        checkOutput("single_cnt_val", 32'(cnt_data_val_o), 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("single_cnt_val_drop", 32'(cnt_data_val_o), 32'h0);
        idle(6);

        // Round-robin with all four requesters continuously valid.
        doReset(1);
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            applyStimulus(4'hF, 8'hFF, 8'h00, 8'h0F, 8'h01);
            @(negedge clk);
            exp_gnt = REQ_NUM'(1) << (i % 4);
            checkOutput("rr_grant", 32'(req_ready), 32'(exp_gnt));
            sb.push_back('{owner: exp_gnt, count: rr_cnt[i % 4]});
        end
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        idle(8);

        // Credit stall against a 10-cycle counter.
        doReset(10);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(4'hF, 8'h03, 8'h07, 8'h80, 8'hAA);
            @(negedge clk);
            exp_gnt = REQ_NUM'(1) << i;
            checkOutput("stall_issue", 32'(req_ready), 32'(exp_gnt));
        end
        sb.push_back('{owner: 4'b0001, count: 4'd2});
        sb.push_back('{owner: 4'b0010, count: 4'd3});
        sb.push_back('{owner: 4'b0100, count: 4'd1});
        sb.push_back('{owner: 4'b1000, count: 4'd4});
        stall = 0;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            nextCycle();
            @(negedge clk);
            if (rsp_val != '0) begin
                found = 1'b1;
                break;
            end
            checkOutput("stall_ready", 32'(req_ready), 32'h0);
            stall++;
        end
        checkOutput("stall_resp_seen", 32'(found), 32'h1);
        checkOutput("stall_cycles", 32'(stall), 32'd8);
        checkOutput("resume_grant", 32'(req_ready), 32'h1);
        sb.push_back('{owner: 4'b0001, count: 4'd2});
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        idle(20);

        // Spurious counter result with nothing outstanding.
        doReset(1);
        nextCycle();
        inject_data = 4'd5;
        inject_val  = 1'b1;
        nextCycle();
        inject_val  = 1'b0;
        @(negedge clk);
        checkOutput("spurious_err", 32'(err), 32'h1);
        checkOutput("spurious_rsp_val", 32'(rsp_val), 32'h0);
        idle(3);
        @(negedge clk);
        checkOutput("spurious_err_sticky", 32'(err), 32'h1);

        // Reset with two words outstanding in a slow counter.
        doReset(10);
        nextCycle();
        applyStimulus(4'hF, 8'h81, 8'h02, 8'h04, 8'h08);
        @(negedge clk);
        checkOutput("mid_grant0", 32'(req_ready), 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("mid_grant1", 32'(req_ready), 32'h2);
        nextCycle();
        srst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("mid_rst_cnt_data", 32'(cnt_data_o), 32'h0);
        checkOutput("mid_rst_cnt_val", 32'(cnt_data_val_o), 32'h0);
        checkOutput("mid_rst_rsp_data", 32'(rsp_data), 32'h0);
        checkOutput("mid_rst_rsp_val", 32'(rsp_val), 32'h0);
        checkOutput("mid_rst_err", 32'(err), 32'h0);
        nextCycle();
        srst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_grant", 32'(req_ready), 32'h1);
        sb.push_back('{owner: 4'b0001, count: 4'd2});
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        idle(20);
        @(negedge clk);
        checkOutput("post_rst_no_err", 32'(err), 32'h0);

        // Requesters 1 and 3 continuously valid.
        doReset(1);
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            applyStimulus(4'b1010, 8'h00, 8'hF0, 8'h00, 8'h3C);
            @(negedge clk);
`ifdef POPCOUNT_ARB_FIXED_PRIO_EN
            exp_gnt = 4'b0010;
`else
            exp_gnt = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            checkOutput("prio_grant", 32'(req_ready), 32'(exp_gnt));
            sb.push_back('{owner: exp_gnt, count: 4'd4});
        end
        nextCycle();
        applyStimulus('0, 8'h00, 8'h00, 8'h00, 8'h00);
        idle(8);

        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
